// File: rtl/ofm_pkg.sv
// Shared types and constants for the OFM write-back path.
package ofm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_CH         = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORDS_PER_BEAT = NUM_CH / BYTES_PER_WORD;
  localparam int BEAT_W         = NUM_CH * 8;
  localparam int WORD_W         = BYTES_PER_WORD * 8;

endpackage

// File: rtl/ofm_writeback_if.sv
// Beat input stream plus BRAM write port of the OFM writer.
interface ofm_writeback_if #(
  parameter int ADDR_W = 32
) ();
  import ofm_pkg::*;

  logic              valid_in;
  logic [BEAT_W-1:0] ofm_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (
    output valid_in, ofm_in,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  valid_in, ofm_in,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/ofm_beat_fifo.sv
// Two-entry FIFO of full 16-channel beats. The caller never pushes when
// full nor pops when empty; flush empties it in one cycle.
module ofm_beat_fifo #(
  parameter int WIDTH = ofm_pkg::BEAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  // Pointer and occupancy tracking; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Storage needs no reset: the reader gates its outputs on occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/ofm_writeback.sv
// OFM write-back: packs 16-byte beats into 32-bit words and writes them
// to the OFM BRAM in NHWC order, tile outer / pixel inner.
// Optional macro OFM_WB_STATS_EN adds the stall_cnt output.
module ofm_writeback #(
  parameter int ADDR_W    = 32,
  parameter int BASE_ADDR = 0,
  parameter int NUM_CH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            OFM_W,
  input  logic [7:0]            OFM_C,
  ofm_writeback_if.slave        bus,
  output logic                  busy,
  output logic                  done,
`ifdef OFM_WB_STATS_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  overflow
);
  import ofm_pkg::*;

  localparam int BEAT_BITS = NUM_CH * 8;

  state_t              state_q, state_d;
  logic [7:0]          cfg_w, cfg_c;
  logic [15:0]         pix_cnt;
  logic [15:0]         pix_last;
  logic [3:0]          tile_cnt;
  logic [3:0]          tiles;
  logic [ADDR_W-1:0]   pix_base;
  logic [ADDR_W-1:0]   pix_step;
  logic [ADDR_W-1:0]   addr;
  logic [1:0]          word_j;
  logic                arm, cfg_zero, drain, beat_end, last_beat;
  logic                push, drop, fifo_full, fifo_empty;
  logic [BEAT_BITS-1:0] head;

  // Start is honoured only outside RUN; it re-arms and flushes stale beats.
  assign arm      = start && (state_q != RUN);
  assign cfg_zero = (OFM_W == 8'd0) || (OFM_C[7:4] == 4'd0);

  assign tiles     = cfg_c[7:4];
  assign pix_last  = ({8'd0, cfg_w} * {8'd0, cfg_w}) - 16'd1;
  assign pix_step  = ADDR_W'({cfg_c[7:4], 2'b00});
  assign drain     = (state_q == RUN) && !fifo_empty;
  assign beat_end  = drain && (word_j == 2'(WORDS_PER_BEAT - 1));
  assign last_beat = (tile_cnt == tiles - 4'd1) && (pix_cnt == pix_last);
  assign push      = (state_q == RUN) && bus.valid_in && !fifo_full;
  assign drop      = (state_q == RUN) && bus.valid_in && fifo_full;

  ofm_beat_fifo #(.WIDTH(BEAT_BITS)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (arm),
    .push  (push),
    .pop   (beat_end),
    .din   (bus.ofm_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; an empty geometry finishes without writing anything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = cfg_zero ? DONE : RUN;
      RUN:        if (beat_end && last_beat) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Config latch, word index and NHWC address counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_w    <= 8'd0;
      cfg_c    <= 8'd0;
      pix_cnt  <= 16'd0;
      tile_cnt <= 4'd0;
      pix_base <= '0;
      word_j   <= 2'd0;
      overflow <= 1'b0;
    end else if (arm) begin
      cfg_w    <= OFM_W;
      cfg_c    <= OFM_C;
      pix_cnt  <= 16'd0;
      tile_cnt <= 4'd0;
      pix_base <= '0;
      word_j   <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (drain) begin
        if (beat_end) begin
          word_j <= 2'd0;
          if (pix_cnt == pix_last) begin
            pix_cnt  <= 16'd0;
            pix_base <= '0;
            tile_cnt <= tile_cnt + 4'd1;
          end else begin
            pix_cnt  <= pix_cnt + 16'd1;
            pix_base <= pix_base + pix_step;
          end
        end else begin
          word_j <= word_j + 2'd1;
        end
      end
    end
  end

`ifdef OFM_WB_STATS_EN
  // Cycles in RUN where the buffer holds two beats; saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              stall_cnt <= 16'd0;
    else if (arm)                                            stall_cnt <= 16'd0;
    else if (state_q == RUN && fifo_full && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  assign addr = ADDR_W'(BASE_ADDR) + pix_base + ADDR_W'({tile_cnt, 2'b00}) + ADDR_W'(word_j);

  assign bus.wr_en   = drain;
  assign bus.wr_addr = drain ? addr : '0;
  assign bus.wr_data = drain ? head[{word_j, 5'b00000} +: WORD_W] : '0;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback: scenario table plus corner sequences.
module tb_ofm_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  OFM_W = 8'd0;
  logic [7:0]  OFM_C = 8'd0;
  logic        busy, done, overflow;
`ifdef OFM_WB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  ofm_writeback_if #(.ADDR_W(32)) bus ();

  ofm_writeback #(.ADDR_W(32), .BASE_ADDR(0), .NUM_CH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .OFM_W    (OFM_W),
    .OFM_C    (OFM_C),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
`ifdef OFM_WB_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      wr_addr_q.push_back(bus.wr_addr);
      wr_data_q.push_back(bus.wr_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  typedef struct {
    logic [7:0] w;
    logic [7:0] c;
    int         beats;
    int         gap;
    int         exp_writes;
    bit         exp_ovf;
    bit         exp_done;
    int         exp_maxrun;
  } scen_t;

  scen_t tab[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] beat_pat(input int b);
    logic [127:0] p;
    for (int k = 0; k < 16; k++) p[8*k +: 8] = 8'(k + 16*b);
    return p;
  endfunction

  function automatic logic [31:0] exp_word(input int b, input int j);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4*j + k + 16*b);
    return w;
  endfunction

  function automatic logic [31:0] exp_addr(input int n, input int w, input int c);
    int b, j, npix, tile, pix;
    b    = n / 4;
    j    = n % 4;
    npix = w * w;
    tile = b / npix;
    pix  = b % npix;
    return 32'(pix * ((c / 16) * 4) + tile * 4 + j);
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    start = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("reset_outputs", {31'd0, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done, overflow}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_scen(input int i, input bit do_reset);
    int base, n, done_cyc, maxrun, run;
    bit got_done;
    if (do_reset) apply_reset();
    base = wr_addr_q.size();
    @(posedge clk); #1;
    OFM_W = tab[i].w;
    OFM_C = tab[i].c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    for (int b = 0; b < tab[i].beats; b++) begin
      bus.valid_in = 1'b1;
      bus.ofm_in   = beat_pat(b);
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      if (b != tab[i].beats - 1) repeat (tab[i].gap - 1) begin @(posedge clk); #1; end
    end
    got_done = 1'b0;
    done_cyc = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    n = wr_addr_q.size() - base;
    chk($sformatf("s%0d_write_count", i), n, tab[i].exp_writes);
    for (int k = 0; k < n && k < tab[i].exp_writes; k++) begin
      chk($sformatf("s%0d_addr%0d", i, k), wr_addr_q[base+k], exp_addr(k, tab[i].w, tab[i].c));
      chk($sformatf("s%0d_data%0d", i, k), wr_data_q[base+k], exp_word(k / 4, k % 4));
    end
    chk($sformatf("s%0d_overflow", i), overflow, tab[i].exp_ovf);
    chk($sformatf("s%0d_done_reached", i), got_done, tab[i].exp_done);
    chk($sformatf("s%0d_busy", i), busy, !tab[i].exp_done);
    if (got_done && n > 0)
      chk($sformatf("s%0d_done_timing", i), done_cyc, wr_cyc_q[base+n-1] + 1);
    maxrun = 0;
    run = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0 && wr_cyc_q[base+k] == wr_cyc_q[base+k-1] + 1) run++;
      else run = 1;
      if (run > maxrun) maxrun = run;
    end
    chk($sformatf("s%0d_max_run", i), maxrun, tab[i].exp_maxrun);
  endtask

  initial begin
    int base;
    bus.valid_in = 1'b0;
    bus.ofm_in   = '0;

    //          w     c      beats gap writes ovf done maxrun
    tab[0] = '{8'd2, 8'd16, 4,    6,  16,    0,  1,   4};
    tab[1] = '{8'd2, 8'd32, 8,    6,  32,    0,  1,   4};
    tab[2] = '{8'd2, 8'd16, 3,    1,  8,     1,  0,   8};
    tab[3] = '{8'd2, 8'd16, 4,    4,  16,    0,  1,   16};
    tab[4] = '{8'd3, 8'd16, 9,    4,  36,    0,  1,   36};

    for (int i = 0; i < 5; i++) run_scen(i, 1'b1);

    // Beats in IDLE are ignored; a zero-tile start finishes with no writes.
    apply_reset();
    base = wr_addr_q.size();
    @(posedge clk); #1;
    bus.ofm_in = beat_pat(0);
    bus.valid_in = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.valid_in = 1'b0;
    chk("idle_no_overflow", overflow, 1'b0);
    OFM_W = 8'd2;
    OFM_C = 8'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("c8_done", done, 1'b1);
    chk("c8_busy", busy, 1'b0);
    bus.valid_in = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.valid_in = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("c8_no_writes", wr_addr_q.size() - base, 0);
    chk("done_state_no_overflow", overflow, 1'b0);

    // Asynchronous reset in the middle of the second beat, then a clean rerun.
    apply_reset();
    @(posedge clk); #1;
    OFM_W = 8'd2;
    OFM_C = 8'd16;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.valid_in = 1'b1;
    bus.ofm_in = beat_pat(0);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    bus.valid_in = 1'b1;
    bus.ofm_in = beat_pat(1);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    chk("midrun_wr_en_before_reset", bus.wr_en, 1'b1);
    chk("midrun_addr_before_reset", bus.wr_addr, 32'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_async_reset", {31'd0, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done, overflow}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_scen(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofm_writeback.md
Name: ofm_writeback

Overview:
- Output-side writer for the conv datapath. Takes the 16 activated OFM channel bytes produced per valid pulse and packs them 4 bytes per 32-bit word.
- Writes the words into the OFM BRAM in NHWC order, generating addresses tile by tile.
- This is the write end of the OFM path. The conv sub-top emits bytes plus valid; this block converts them into BRAM write cycles (wr_rd_en/addr/data_in style).

Parameters:
- ADDR_W, 32, width of wr_addr.
- BASE_ADDR, 0, word address of OFM pixel 0, channel 0.
- NUM_CH, 16, channels delivered per valid_in; fixed at 16, so 4 words per beat.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; latches OFM_W/OFM_C and arms the writer.
- OFM_W  input  8  output feature-map width/height (square map).
- OFM_C  input  8  output channel count; tiles = OFM_C>>4.
- valid_in  input  1  a 16-byte beat is present on ofm_in.
- ofm_in  input  128  channel k of the current tile is at bits [8k+7:8k].
- wr_en  output  1  BRAM write strobe (1 = write).
- wr_addr  output  ADDR_W  BRAM word address.
- wr_data  output  32  packed word; byte b (bits [8b+7:8b]) = channel 4j+b.
- busy  output  1  high from the cycle after start until done.
- done  output  1  level; high once all beats are written, cleared by the next start.
- overflow  output  1  sticky; a beat was dropped because the buffer was full.

Behaviour:
- Reset (async, rst_n=0): every output is 0 (wr_en, wr_addr, wr_data, busy, done, overflow). Buffer is emptied, counters zeroed, FSM goes to IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. Config is latched; pix_cnt=0, tile_cnt=0, pix_base=0.
  - If latched OFM_W==0 or (OFM_C>>4)==0, IDLE -> DONE instead.
  - RUN -> DONE after the last word of the last beat has been written.
  - DONE -> RUN on start (re-arms; clears done and overflow).
- start while in RUN is ignored.
- Buffer: 2-entry FIFO of 128-bit beats.
  - valid_in is accepted only in RUN. It is ignored in IDLE and DONE, and does not set overflow there.
  - A beat arriving when both entries are full is dropped, sets overflow, and is not counted.
- Drain: a word index j cycles 0..3 over the head entry, one word per cycle while the FIFO is non-empty.
  - wr_data = head[32j+31:32j]; wr_en=1.
  - The head entry is popped after j=3.
  - Push and pop in the same cycle are both honoured.
- Latency: valid_in at cycle t with an empty FIFO gives wr_en at t+1..t+4. Back-to-back beats every 4 cycles give continuous wr_en.
- Address: wr_addr = BASE_ADDR + pix_base + tile_cnt*4 + j.
  - pix_base advances by OFM_C>>2 after each beat's j=3.
  - After the beat with pix_cnt = OFM_W*OFM_W-1: pix_cnt=0, pix_base=0, tile_cnt+1.
  - Order is tile outer, pixel inner, which matches the compute order (one filter tile per window sweep).
- Arithmetic: pixel count is 16 bits (OFM_W*OFM_W ≤ 65025); pix_base is ADDR_W bits; no wrap inside a run.
- The last beat is tile_cnt = tiles-1 and pix_cnt = last. The transition to DONE occurs on its j=3 cycle; busy falls and done rises the next cycle.
- Beats beyond the total while in DONE are ignored.
- OFM_C bits [3:0] are ignored.
- Reset mid-run aborts immediately. Partially written BRAM contents are not rolled back.

Optional Feature:
- OFM_WB_STATS_EN defined: adds output stall_cnt [15:0]. It counts cycles in RUN with a non-empty FIFO and full occupancy (2 entries), saturates at 16'hFFFF, is cleared by start and reset, and reads 0 in IDLE.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package ofm_pkg:
  - state enum {IDLE, RUN, DONE}.
  - constants NUM_CH=16, BYTES_PER_WORD=4, WORDS_PER_BEAT=4.
- One sub-module: ofm_beat_fifo (2-entry, 128-bit, push/pop/full/empty).
- Address counters and FSM stay in ofm_writeback.

Test Plan:
- OFM_W=2, OFM_C=16, 4 beats spaced 6 cycles, ofm_in bytes = k+16*beat
  -> 16 writes, addr 0..15, word 0 = 32'h03020100, done after last write, overflow=0.
- OFM_W=2, OFM_C=32, 8 beats
  -> tile0 addrs {0-3, 8-11, 16-19, 24-27}, tile1 addrs {4-7, 12-15, 20-23, 28-31}.
- Three valid_in beats on consecutive cycles, OFM_W=2, OFM_C=16
  -> third beat dropped, overflow=1; 8 writes total; done never rises.
- Beats every 4 cycles, 4 beats
  -> wr_en continuously high for 16 cycles, no overflow.
- start with OFM_C=8
  -> done=1 two cycles later, no wr_en.
- rst_n low during 2nd beat of the first scenario
  -> all outputs 0 asynchronously; a fresh start rewrites from addr BASE_ADDR.
